r2r_dac_wavegen: RTL and testbench

Parametrised waveform controller for the R2R DAC: a `WIDTH`-bit output drives the resistor ladder directly. Sources are external pass-through data, sawtooth, triangle or square, each advanced by a programmable clock-divider tick. Divider and amplitude are loaded from the shared `data` bus. Sits between the top-level `ui_in` pins and the analog R2R ladder, with a per-step strobe for scope triggering.

---
 rtl/r2r_dac_wavegen.sv | 119 +++++++++++
 tb/tb_r2r_dac_wavegen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/r2r_dac_wavegen.sv
// R2R ladder waveform controller: external pass-through, sawtooth, triangle and square outputs.
// The amplitude register is only built when R2R_WAVEGEN_AMP_EN is defined; otherwise amplitude is all ones.
module r2r_dac_wavegen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             load_divider,
  input  logic             load_amp,
  output logic [WIDTH-1:0] r2r_out,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_EXT = 2'b00,
    MODE_SAW = 2'b01,
    MODE_TRI = 2'b10,
    MODE_SQR = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  mode_t             mode_sel;
  mode_t             prev_mode;
  dir_t              dir;
  dir_t              dir_next;
  logic [WIDTH-1:0]  divider;
  logic [WIDTH-1:0]  amp;
  logic [DIV_W-1:0]  counter;
  logic [DIV_W-1:0]  thresh;
  logic              tick;
  logic              mode_change;
  logic [WIDTH-1:0]  wave_next;

  assign mode_sel    = mode_t'(mode);
  assign mode_change = (mode_sel != prev_mode);
  // Divider sits in the top bits of the tick threshold
  assign thresh      = DIV_W'(divider) << (DIV_W - WIDTH);
  assign tick        = (counter >= thresh);

`ifdef R2R_WAVEGEN_AMP_EN
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      amp <= '1;
    end else if (load_amp) begin
      amp <= data;
    end
  end
`else
  logic unused_load_amp;
  assign unused_load_amp = load_amp;
  assign amp = '1;
`endif

  always_comb begin
    wave_next = r2r_out;
    dir_next  = dir;
    case (mode_sel)
      MODE_SAW: wave_next = (r2r_out >= amp) ? '0 : r2r_out + 1'b1;
      MODE_TRI: begin
        if (dir == DIR_UP) begin
          if (r2r_out >= amp) begin
            dir_next  = DIR_DOWN;
            wave_next = (r2r_out == '0) ? '0 : r2r_out - 1'b1;
          end else begin
            wave_next = r2r_out + 1'b1;
          end
        end else if (r2r_out == '0) begin
          dir_next  = DIR_UP;
          wave_next = (amp == '0) ? '0 : WIDTH'(1);
        end else begin
          wave_next = r2r_out - 1'b1;
        end
      end
      MODE_SQR: wave_next = (r2r_out == '0) ? amp : '0;
      default:  wave_next = data;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r2r_out   <= '0;
      step      <= 1'b0;
      divider   <= '0;
      counter   <= '0;
      dir       <= DIR_UP;
      prev_mode <= MODE_EXT;
    end else begin
      step      <= 1'b0;
      prev_mode <= mode_sel;
      if (load_divider) begin
        divider <= data;
      end
      // A mode change restarts the waveform and suppresses any tick that cycle
      if (mode_change) begin
        counter <= '0;
        dir     <= DIR_UP;
        r2r_out <= (mode_sel == MODE_EXT) ? data : '0;
      end else if (mode_sel == MODE_EXT) begin
        counter <= '0;
        r2r_out <= data;
      end else if (tick) begin
        counter <= '0;
        r2r_out <= wave_next;
        dir     <= dir_next;
        step    <= 1'b1;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_r2r_dac_wavegen.sv
// Randomised and directed bench for r2r_dac_wavegen against an integer reference model.
// Follows R2R_WAVEGEN_AMP_EN so the model matches whichever build is compiled.
module tb_r2r_dac_wavegen;
  localparam int WIDTH = 8;
  localparam int DIV_W = 16;
  localparam int AMAX  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] data = '0;
  logic             load_divider = 1'b0;
  logic             load_amp = 1'b0;
  logic [WIDTH-1:0] r2r_out;
  logic             step;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, held as plain integers
  int m_out, m_div, m_amp, m_cnt, m_prev;
  bit m_step, m_up;

  r2r_dac_wavegen #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .data(data),
    .load_divider(load_divider), .load_amp(load_amp),
    .r2r_out(r2r_out), .step(step)
  );

  always #50 clk = ~clk;

  task automatic model_reset();
    m_out = 0; m_step = 0; m_div = 0; m_amp = AMAX; m_cnt = 0; m_up = 1; m_prev = 0;
  endtask

  task automatic model_update();
    int t;
    t = m_div * (1 << (DIV_W - WIDTH));
    m_step = 0;
    if (int'(mode) != m_prev) begin
      m_cnt = 0; m_up = 1;
      m_out = (mode == 2'b00) ? int'(data) : 0;
    end else if (mode == 2'b00) begin
      m_cnt = 0; m_out = int'(data);
    end else if (m_cnt >= t) begin
      m_cnt = 0; m_step = 1;
      case (mode)
        2'b01: m_out = (m_out >= m_amp) ? 0 : m_out + 1;
        2'b10: begin
          if (m_up) begin
            if (m_out >= m_amp) begin m_up = 0; m_out = (m_out == 0) ? 0 : m_out - 1; end
            else m_out = m_out + 1;
          end else begin
            if (m_out == 0) begin m_up = 1; m_out = (m_amp == 0) ? 0 : 1; end
            else m_out = m_out - 1;
          end
        end
        default: m_out = (m_out == 0) ? m_amp : 0;
      endcase
    end else begin
      m_cnt = m_cnt + 1;
    end
    if (load_divider) m_div = int'(data);
`ifdef R2R_WAVEGEN_AMP_EN
    if (load_amp) m_amp = int'(data);
`endif
    m_prev = int'(mode);
  endtask

  // One clock: model follows the edge when out of reset, outputs settle 1 time unit later
  task automatic clock_once();
    @(posedge clk);
    if (n_rst) model_reset(); else model_update();
    #1;
  endtask

  task automatic applyLoads(input logic [WIDTH-1:0] div_val, input logic [WIDTH-1:0] amp_val);
    mode = 2'b00; load_amp = 1'b0;
    data = div_val; load_divider = 1'b1; clock_once();
    load_divider = 1'b0; data = amp_val; load_amp = 1'b1; clock_once();
    load_amp = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) clock_once();
    vectors++;
    if (r2r_out !== '0 || step !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset: out=%h step=%b, want out=00 step=0", r2r_out, step);
    end
    n_rst = 1'b0;
  endtask

  task automatic test_external();
    mode = 2'b00; data = 8'hA5; clock_once();
    vectors++;
    if (r2r_out !== 8'hA5 || step !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL external_a5: out=%h step=%b, want out=a5 step=0", r2r_out, step);
    end
    for (int i = 0; i < 20; i++) begin
      data = $urandom; clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL external_rand: out=%h step=%b, want out=%h step=0", r2r_out, step, m_out);
      end
    end
  endtask

  task automatic test_sawtooth_fast();
    applyLoads(8'h00, 8'hFF);
    mode = 2'b01;
    for (int i = 0; i < 300; i++) begin
      data = $urandom; clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(i % 256) || step !== (i > 0) || r2r_out !== WIDTH'(m_out)) begin
        miscompares++;
        $display("[TB] FAIL saw_fast[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, i % 256, i > 0);
      end
    end
  endtask

  task automatic test_divider();
    int steps = 0;
    applyLoads(8'h01, 8'hFF);
    mode = 2'b01;
    for (int i = 0; i < 800; i++) begin
      clock_once();
      steps += int'(step);
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== m_step) begin
        miscompares++;
        $display("[TB] FAIL divider[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, m_out, m_step);
      end
    end
    vectors++;
    if (steps != 3 || r2r_out !== 8'h03) begin
      miscompares++;
      $display("[TB] FAIL divider_count: steps=%0d out=%h, want steps=3 out=03", steps, r2r_out);
    end
  endtask

  task automatic test_triangle();
    int seq [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    applyLoads(8'h00, 8'h03);
    mode = 2'b10;
    clock_once();
    for (int i = 0; i < 8; i++) begin
      clock_once();
      vectors++;
`ifdef R2R_WAVEGEN_AMP_EN
      if (r2r_out !== WIDTH'(seq[i]) || step !== 1'b1) begin
`else
      if (r2r_out !== WIDTH'(m_out) || step !== 1'b1 || seq[0] != 1) begin
`endif
        miscompares++;
        $display("[TB] FAIL triangle[%0d]: out=%h step=%b, want out=%h step=1", i, r2r_out, step, m_out);
      end
    end
    data = 8'h00; load_amp = 1'b1; clock_once(); load_amp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== m_step) begin
        miscompares++;
        $display("[TB] FAIL triangle_amp0[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, m_out, m_step);
      end
    end
  endtask

  task automatic test_square_switch();
    applyLoads(8'h00, 8'h40);
    mode = 2'b11;
    for (int i = 0; i < 7; i++) begin
      clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== m_step) begin
        miscompares++;
        $display("[TB] FAIL square[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, m_out, m_step);
      end
    end
    mode = 2'b01; clock_once();
    vectors++;
    if (r2r_out !== '0 || step !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL square_to_saw: out=%h step=%b, want out=00 step=0", r2r_out, step);
    end
  endtask

  task automatic test_reset_midrun();
    applyLoads(8'h00, 8'h05);
    mode = 2'b10;
    repeat (7) clock_once();
    n_rst = 1'b1; #1;
    model_reset();
    vectors++;
    if (r2r_out !== '0 || step !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midrun: out=%h step=%b, want out=00 step=0", r2r_out, step);
    end
    clock_once();
    n_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== m_step) begin
        miscompares++;
        $display("[TB] FAIL after_reset[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, m_out, m_step);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom);
      data = $urandom;
      load_divider = ($urandom_range(31) == 0);
      if (load_divider) data = WIDTH'($urandom_range(3));
      load_amp = ($urandom_range(15) == 0);
      clock_once();
      vectors++;
      if (r2r_out !== WIDTH'(m_out) || step !== m_step) begin
        miscompares++;
        $display("[TB] FAIL random[%0d]: out=%h step=%b, want out=%h step=%b", i, r2r_out, step, m_out, m_step);
      end
    end
    load_divider = 1'b0; load_amp = 1'b0;
  endtask

  initial begin
    test_reset();
    test_external();
    test_sawtooth_fast();
    test_divider();
    test_triangle();
    test_square_switch();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
